// File: rtl/uart_pkg.sv
// uart_pkg: 16550 register map, LSR bit positions and loopback sequencer states.
package uart_pkg;
   localparam logic [2:0] A_RBR = 3'd0;
   localparam logic [2:0] A_THR = 3'd0;
   localparam logic [2:0] A_LCR = 3'd3;
   localparam logic [2:0] A_LSR = 3'd5;
   localparam int LSR_DR = 0;
   localparam int LSR_TEMT = 6;
   typedef logic [2:0] state_t;
   localparam state_t S_IDLE = 3'd0;
   localparam state_t S_CFG  = 3'd1;
   localparam state_t S_TXW  = 3'd2;
   localparam state_t S_PT   = 3'd3;
   localparam state_t S_PR   = 3'd4;
   localparam state_t S_RXR  = 3'd5;
   localparam state_t S_CMP  = 3'd6;
   localparam state_t S_DONE = 3'd7;
endpackage

// File: rtl/uart_reg_access.sv
// uart_reg_access: one register read or write per req, acked when complete.
// Reads capture rx_data RD_LAT cycles after the rx_en strobe cycle.
module uart_reg_access
   import uart_pkg::*;
#(
   parameter int RD_LAT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic       we,
   input  logic [2:0] addr,
   input  logic [7:0] wr_data,
   output logic       ack,
   output logic [7:0] rd_data,
   output logic       tx_en,
   output logic [2:0] tx_addr,
   output logic [7:0] tx_data,
   output logic       rx_en,
   output logic [2:0] rx_addr,
   input  logic [7:0] rx_data
);
   logic       act;
   logic       rd;
   logic [7:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act     <= 1'b0;
         rd      <= 1'b0;
         cnt     <= 8'd0;
         ack     <= 1'b0;
         rd_data <= 8'd0;
         tx_en   <= 1'b0;
         tx_addr <= 3'd0;
         tx_data <= 8'd0;
         rx_en   <= 1'b0;
         rx_addr <= 3'd0;
      end else begin
         tx_en   <= 1'b0;
         rx_en   <= 1'b0;
         tx_data <= 8'd0;
         ack     <= 1'b0;
         if (!act) begin
            if (req) begin
               act   <= 1'b1;
               rd    <= !we;
               cnt   <= 8'd0;
               tx_en <= we;
               rx_en <= !we;
               if (we) begin
                  tx_addr <= addr;
                  tx_data <= wr_data;
               end else
                  rx_addr <= addr;
            end
         end else if (!rd || cnt == 8'(RD_LAT)) begin
            act <= 1'b0;
            ack <= 1'b1;
            if (rd) rd_data <= rx_data;
         end else
            cnt <= cnt + 8'd1;
      end
   end
endmodule

// File: rtl/uart_loop_seq.sv
// uart_loop_seq: configures a 16550-style UART and runs a NUM_BYTES TX->RX
// loopback check, reporting mismatches and LSR poll timeouts per run.
module uart_loop_seq
   import uart_pkg::*;
#(
   parameter int         NUM_BYTES = 4,
   parameter logic [7:0] LCR_VAL   = 8'h2B,
   parameter int         RD_LAT    = 2,
   parameter int         TMO_W     = 16
) (
   input  logic       I_CLK,
   input  logic       I_RESET,
   input  logic       I_START,
   input  logic [7:0] I_SEED,
   output logic       O_TX_EN,
   output logic [2:0] O_WADDR,
   output logic [7:0] O_WDATA,
   output logic       O_RX_EN,
   output logic [2:0] O_RADDR,
   input  logic [7:0] I_RDATA,
   output logic       O_BUSY,
   output logic       O_DONE,
   output logic       O_PASS,
   output logic [7:0] O_ERR_CNT,
   output logic       O_TIMEOUT
);
   state_t           state;
   logic             start_q;
   logic             pend;
   logic             req;
   logic             we;
   logic             ack;
   logic             polled;
   logic             last;
   logic [2:0]       addr;
   logic [7:0]       seed;
   logic [7:0]       k;
   logic [7:0]       err;
   logic [7:0]       err_n;
   logic [7:0]       rdata;
   logic [7:0]       exp_byte;
   logic [7:0]       wr_data;
   logic [TMO_W-1:0] tmo;
   logic [TMO_W-1:0] tmo_n;

   // pend keeps req to a single cycle per transaction while the access is in flight
   always_comb begin
      req      = (state inside {S_CFG, S_TXW, S_PT, S_PR, S_RXR}) && !pend;
      we       = state == S_CFG || state == S_TXW;
      addr     = state == S_CFG ? A_LCR : state == S_TXW ? A_THR : state == S_RXR ? A_RBR : A_LSR;
      exp_byte = seed + k;
      wr_data  = state == S_CFG ? LCR_VAL : exp_byte;
      tmo_n    = tmo + TMO_W'(1);
      err_n    = (rdata != exp_byte && err != 8'hFF) ? err + 8'd1 : err;
      polled   = state == S_PT ? rdata[LSR_TEMT] : rdata[LSR_DR];
      last     = k == 8'(NUM_BYTES - 1);
   end

   assign O_BUSY = state != S_IDLE;
   assign O_DONE = state == S_DONE;

   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         state     <= S_IDLE;
         start_q   <= 1'b0;
         pend      <= 1'b0;
         seed      <= 8'd0;
         k         <= 8'd0;
         err       <= 8'd0;
         tmo       <= '0;
         O_PASS    <= 1'b0;
         O_ERR_CNT <= 8'd0;
         O_TIMEOUT <= 1'b0;
      end else begin
         start_q <= I_START;
         if (req) pend <= 1'b1;
         else if (ack) pend <= 1'b0;
         case (state)
            S_IDLE: if (I_START && !start_q) begin
               seed  <= I_SEED;
               k     <= 8'd0;
               err   <= 8'd0;
               state <= S_CFG;
            end
            S_CFG: if (ack) state <= S_TXW;
            S_TXW: if (ack) begin
               tmo   <= '0;
               state <= S_PT;
            end
            S_PT, S_PR: if (ack) begin
               if (polled) begin
                  tmo   <= '0;
                  state <= state == S_PT ? S_PR : S_RXR;
               end else if (&tmo_n) begin
                  O_ERR_CNT <= err;
                  O_TIMEOUT <= 1'b1;
                  O_PASS    <= 1'b0;
                  state     <= S_DONE;
               end else
                  tmo <= tmo_n;
            end
            S_RXR: if (ack) state <= S_CMP;
            S_CMP: begin
               err <= err_n;
               if (last) begin
                  O_ERR_CNT <= err_n;
                  O_TIMEOUT <= 1'b0;
                  O_PASS    <= err_n == 8'd0;
                  state     <= S_DONE;
               end else begin
                  k     <= k + 8'd1;
                  state <= S_TXW;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   uart_reg_access #(.RD_LAT(RD_LAT)) u_acc (
      .clk     (I_CLK),
      .rst     (I_RESET),
      .req     (req),
      .we      (we),
      .addr    (addr),
      .wr_data (wr_data),
      .ack     (ack),
      .rd_data (rdata),
      .tx_en   (O_TX_EN),
      .tx_addr (O_WADDR),
      .tx_data (O_WDATA),
      .rx_en   (O_RX_EN),
      .rx_addr (O_RADDR),
      .rx_data (I_RDATA)
   );
endmodule

// File: doc/uart_loop_seq.md
UART_LOOP_SEQ -- requirements
Module: uart_loop_seq

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_BYTES, 4: bytes per run, 1..255.
- LCR_VAL, 8'h2B: value written to LCR.
- RD_LAT, 2: cycles from O_RX_EN assertion to I_RDATA valid.
- TMO_W, 16: poll-timeout counter width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- I_CLK, in, 1: single clock.
- I_RESET, in, 1: asynchronous, active-high reset.
- I_START, in, 1: rising-edge run request.
- I_SEED, in, 8: first expected byte.
- O_TX_EN, out, 1: register write strobe.
- O_WADDR, out, 3: register write address.
- O_WDATA, out, 8: register write data.
- O_RX_EN, out, 1: register read strobe.
- O_RADDR, out, 3: register read address.
- I_RDATA, in, 8: register read data.
- O_BUSY, out, 1: run in progress.
- O_DONE, out, 1: one-cycle pulse at run end.
- O_PASS, out, 1: last run had no errors and no timeout.
- O_ERR_CNT, out, 8: mismatches in the last run.
- O_TIMEOUT, out, 1: last run aborted on a poll timeout.

Function
REQ-003 The block SHALL drive a 16550-style register port and run a TX->RX loopback test of NUM_BYTES bytes per run.
REQ-004 A run SHALL start only on a 0->1 transition of I_START, sampled against a registered copy, while the FSM is in IDLE; edges seen while O_BUSY=1 SHALL be ignored.
REQ-005 Every write SHALL assert O_TX_EN for exactly one cycle with O_WADDR/O_WDATA valid in that cycle; the next cycle SHALL have O_TX_EN=0 and O_WDATA=0.
REQ-006 Every read SHALL assert O_RX_EN for exactly one cycle; I_RDATA SHALL be captured exactly RD_LAT cycles after that assertion.
REQ-007 FSM states and transitions SHALL be:
- IDLE -> CFG, which writes LCR_VAL to address 3.
- CFG -> TXW, which writes byte k to address 0 (THR).
- TXW -> PT, which polls LSR (address 5) until bit 6 (TEMT) = 1.
- PT -> PR, which polls LSR until bit 0 (DR) = 1.
- PR -> RXR, which reads address 0 (RBR).
- RXR -> CMP; CMP -> TXW while k < NUM_BYTES-1, else DONE.
- DONE -> IDLE.
REQ-008 Byte k SHALL equal (I_SEED + k) mod 256, with I_SEED latched at run start.
REQ-009 In CMP, a received byte that differs from byte k SHALL increment the error counter, which saturates at 8'hFF.
REQ-010 Each poll state SHALL count LSR reads; reaching 2^TMO_W-1 reads without the awaited bit SHALL go to DONE with O_TIMEOUT=1 and no further bytes sent.
REQ-011 The poll counter SHALL clear on entry to every poll state.
REQ-012 In DONE, the block SHALL pulse O_DONE for one cycle and update O_ERR_CNT, O_TIMEOUT, and O_PASS=(err==0 && !timeout).
- These outputs SHALL hold until the next DONE.
REQ-013 O_BUSY SHALL be 1 from the cycle after a start is accepted through the DONE cycle inclusive.
REQ-014 Only one of O_TX_EN/O_RX_EN SHALL be high in any cycle.

Reset
REQ-015 While I_RESET=1, all outputs SHALL be 0, the FSM SHALL be in IDLE, and the counters and registered start copy SHALL be 0.
REQ-016 A reset asserted mid-run SHALL abort immediately with no O_DONE pulse.
- The first I_START edge after release SHALL start a fresh run.

Structure
REQ-017 A shared package uart_pkg SHALL hold:
- Register address constants: RBR/THR=0, LCR=3, LSR=5.
- LSR bit indices: DR=0, TEMT=6.
- The FSM state enumeration.
REQ-018 One sub-module, uart_reg_access, SHALL perform a single read or write transaction with req/ack handshake and RD_LAT capture; the FSM SHALL instantiate it once.

Verification
REQ-019 Loopback pass: SIN tied to SOUT, I_SEED=8'h06, NUM_BYTES=4, one I_START edge -> bytes 06,07,08,09 written; O_DONE pulses once; O_PASS=1; O_ERR_CNT=0.
REQ-020 Single corruption: bench flips bit 0 of the 2nd RBR read -> O_ERR_CNT=1, O_PASS=0, O_TIMEOUT=0.
REQ-021 Poll timeout: TMO_W=4, LSR held at 8'h00 -> 15 LSR reads then DONE; O_TIMEOUT=1, O_PASS=0, exactly one THR write.
REQ-022 Start during busy: second I_START edge mid-run -> ignored; exactly NUM_BYTES THR writes and one O_DONE.
REQ-023 Reset mid-run: I_RESET pulsed during PR of byte 2 -> all outputs 0, no O_DONE; the next start gives a full passing run starting with the LCR write of 8'h2B.
REQ-024 Strobe protocol check on every cycle: O_TX_EN and O_RX_EN are never both 1, and each strobe is high for a single cycle only.
